// File: rtl/inst_fifo.sv
// inst_fifo: dual-port instruction buffer between 64-bit fetch and dual-issue decode
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   flush                       synchronous clear of all entries (redirect)
//   write_en1/2, write_data1/2,
//   write_addr1/2               push 0..2 {instruction, PC} pairs, slot 1 older
//   read_en1/2                  pop 0..2 entries from the head
//   read_data1/2, read_addr1/2,
//   read_valid1/2               head and head+1 entries, zero when not present
//   empty, almost_empty, full   occupancy flags (full means fewer than 2 free slots)
//   occupancy                   entry count, present only with INST_FIFO_COUNT_EN
module inst_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          write_en1,
  input  logic          write_en2,
  input  logic [DW-1:0] write_data1,
  input  logic [DW-1:0] write_data2,
  input  logic [DW-1:0] write_addr1,
  input  logic [DW-1:0] write_addr2,
  input  logic          read_en1,
  input  logic          read_en2,
  output logic [DW-1:0] read_data1,
  output logic [DW-1:0] read_data2,
  output logic [DW-1:0] read_addr1,
  output logic [DW-1:0] read_addr2,
  output logic          read_valid1,
  output logic          read_valid2,
  output logic          empty,
  output logic          almost_empty,
  output logic          full
`ifdef INST_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] occupancy
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] addr_q [DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d, wr_ptr_n;
  ptr_t rd_ptr_q, rd_ptr_d, rd_ptr_n;
  cnt_t count_q, count_d;
  logic [1:0] wn, rn;
  logic wr_ok;
  assign wr_ptr_n     = wr_ptr_q + ptr_t'(1);
  assign rd_ptr_n     = rd_ptr_q + ptr_t'(1);
  assign read_valid1  = count_q != '0;
  assign read_valid2  = count_q > cnt_t'(1);
  assign empty        = count_q == '0;
  assign almost_empty = count_q == cnt_t'(1);
  assign full         = count_q >= cnt_t'(DEPTH - 1);
  assign read_data1   = read_valid1 ? data_q[rd_ptr_q] : '0;
  assign read_addr1   = read_valid1 ? addr_q[rd_ptr_q] : '0;
  assign read_data2   = read_valid2 ? data_q[rd_ptr_n] : '0;
  assign read_addr2   = read_valid2 ? addr_q[rd_ptr_n] : '0;
`ifdef INST_FIFO_COUNT_EN
  assign occupancy    = count_q;
`endif
  // full looks at the current count only, so a same-cycle pop never admits a push
  assign wr_ok = write_en1 & ~full & ~flush;
  assign wn    = wr_ok ? (write_en2 ? 2'd2 : 2'd1) : 2'd0;
  assign rn    = flush ? 2'd0 :
                 (read_en1 & read_en2 & read_valid2) ? 2'd2 :
                 (read_en1 & read_valid1) ? 2'd1 : 2'd0;
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + ptr_t'(wn);
    rd_ptr_d = flush ? '0 : rd_ptr_q + ptr_t'(rn);
    count_d  = flush ? '0 : count_q + cnt_t'(wn) - cnt_t'(rn);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // storage is deliberately not reset; read outputs are masked by the valids
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      data_q[wr_ptr_q] <= write_data1;
      addr_q[wr_ptr_q] <= write_addr1;
      if (write_en2) begin
        data_q[wr_ptr_n] <= write_data2;
        addr_q[wr_ptr_n] <= write_addr2;
      end
    end
  end
endmodule
